// File: rtl/dff_arb_pkg.sv
// rtl/dff_arb_pkg.sv - shared types and default sizes for the dff write arbiter
package dff_arb_pkg;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_MAX_LOCK = 8;
    localparam int OWNER_W      = $clog2(DEF_N_REQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        LOCKED = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker starting the scan at ptr
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down so the nearest set bit after ptr wins.
    always_comb begin
        valid  = |req;
        idx    = '0;
        sum    = '0;
        cand   = '0;
        onehot = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (sum >= (IDX_W + 1)'(N_REQ)) begin
                sum = sum - (IDX_W + 1)'(N_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (req[cand]) begin
                idx = cand;
            end
        end
        onehot[idx] = valid;
    end

endmodule

// File: rtl/dff_arbiter.sv
// rtl/dff_arbiter.sv - round-robin write arbiter for a shared dff; DFF_ARB_LOCK_EN adds locked bursts
module dff_arbiter
    import dff_arb_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX_LOCK = DEF_MAX_LOCK
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         lock,
    input  logic [N_REQ*WIDTH-1:0]   data,
    output logic [N_REQ-1:0]         gnt,
    output logic                     dff_en,
    output logic [WIDTH-1:0]         dff_d,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_e       state;
    logic [IDX_W-1:0] ptr;
    logic             win_valid;
    logic [IDX_W-1:0] win_idx;
    logic [N_REQ-1:0] win_oh;
    logic [WIDTH-1:0] data_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign data_arr[g] = data[g*WIDTH +: WIDTH];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .valid  (win_valid),
        .idx    (win_idx),
        .onehot (win_oh)
    );

`ifdef DFF_ARB_LOCK_EN
    localparam int CNT_W = $clog2(MAX_LOCK);
    logic [CNT_W-1:0] lock_cnt;
`else
    logic unused_lock;
    assign unused_lock = ^lock ^ (MAX_LOCK > 0);
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            gnt    <= '0;
            dff_en <= 1'b0;
            dff_d  <= '0;
            owner  <= '0;
`ifdef DFF_ARB_LOCK_EN
            lock_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        gnt    <= win_oh;
                        dff_en <= 1'b1;
                        dff_d  <= data_arr[win_idx];
                        owner  <= win_idx;
                        ptr    <= (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
                        state  <= GRANT;
                    end
                end
                GRANT: begin
`ifdef DFF_ARB_LOCK_EN
                    if (lock[owner]) begin
                        dff_d    <= data_arr[owner];
                        lock_cnt <= CNT_W'(1);
                        state    <= LOCKED;
                    end else begin
                        gnt    <= '0;
                        dff_en <= 1'b0;
                        state  <= IDLE;
                    end
`else
                    gnt    <= '0;
                    dff_en <= 1'b0;
                    state  <= IDLE;
`endif
                end
`ifdef DFF_ARB_LOCK_EN
                LOCKED: begin
                    // dff_d is left alone on exit so it never moves while dff_en is low.
                    if (!lock[owner] || lock_cnt == CNT_W'(MAX_LOCK - 1)) begin
                        gnt    <= '0;
                        dff_en <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        dff_d    <= data_arr[owner];
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    gnt    <= '0;
                    dff_en <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dff_arbiter.md
# dff_arbiter

Round-robin write arbiter that shares one `dff` storage register between `N_REQ` requesters. It sits between the requester agents and the `dff` datapath: it picks one requester, drives the register's data and enable for that requester, and returns a one-hot grant. An optional lock mode lets a winner hold the register for consecutive writes.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `WIDTH`, default 8: data width of the shared register.
- `MAX_LOCK`, default 8: maximum number of cycles a locked grant may persist (lock build only).
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N_REQ  per-requester write request, level.
- `lock`  in  N_REQ  per-requester lock request; ignored unless `DFF_ARB_LOCK_EN` is defined.
- `data`  in  N_REQ*WIDTH  requester write data; requester i occupies bits [i*WIDTH +: WIDTH].
- `gnt`  out  N_REQ  one-hot grant, registered.
- `dff_en`  out  1  write enable to the `dff`, registered.
- `dff_d`  out  WIDTH  write data to the `dff`, registered.
- `owner`  out  $clog2(N_REQ)  index of the current or most recent grantee.
- `busy`  out  1  high when state is not IDLE.

## Operation
- States: IDLE, GRANT, LOCKED. LOCKED exists only in the lock build.
- Priority pointer `ptr`:
  - `ptr` marks the highest-priority requester.
  - Winner w is the first set `req` bit found scanning ptr, ptr+1, … with wrap from N_REQ-1 to 0.
- IDLE with `req` != 0, at that edge:
  - `gnt` <= onehot(w), `dff_en` <= 1, `dff_d` <= data[w], `owner` <= w.
  - `ptr` <= (w+1) mod N_REQ.
  - Next state is GRANT.
- IDLE with `req` == 0: all outputs hold their idle values (`gnt`=0, `dff_en`=0). `dff_d` and `owner` keep their last values.
- GRANT:
  - Without lock (or lock build with `lock[w]`=0): next state is IDLE, `gnt` <= 0, `dff_en` <= 0.
  - Lock build with `lock[w]`=1: next state is LOCKED, `gnt` and `dff_en` stay asserted, `dff_d` <= data[w], lock counter <= 1.
- LOCKED:
  - Each cycle: `dff_d` <= data[w] and the counter increments.
  - Exit to IDLE (`gnt` and `en` cleared) when `lock[w]`=0 or the counter reaches MAX_LOCK-1.
- Turnaround: GRANT always passes through IDLE, so no requester is re-granted in the cycle after its grant. Peak throughput is one write per 2 cycles.
- Requester rules:
  - A requester holds `req` until it sees its `gnt`, then deasserts `req` on the following edge.
  - Withdrawing `req` before a grant is legal; a withdrawn request is never granted.
- Other `req`/`data` changes during GRANT or LOCKED are ignored.

## Timing
- Reset values: `gnt`=0, `dff_en`=0, `dff_d`=0, `owner`=0, `busy`=0, `ptr`=0, state IDLE, lock counter 0.
- Reset asserted mid-grant clears every output at the next edge. No partial write follows.
- Latency:
  - `req` high before edge k gives `gnt`/`dff_en` high during cycle k+1.
  - The `dff` captures `dff_d` at edge k+1.
  - `dff` q is valid in cycle k+2.
- `dff_d` equals `data[w]` as sampled at the decision edge (or per-cycle in LOCKED). It never changes while `dff_en`=0 except on reset.
- All-requesters-active: grants rotate 0,1,2,3,0… starting from `ptr`.
- Wrap-around: the pointer moves from N_REQ-1 to 0.
- Single requester: that requester is granted every 2nd cycle.
- `dff_en` is never asserted without exactly one `gnt` bit set.

## Configuration
- `DFF_ARB_LOCK_EN` defined:
  - LOCKED state, lock counter and `lock` input are active.
  - A grant may extend up to MAX_LOCK consecutive write cycles.
- `DFF_ARB_LOCK_EN` undefined:
  - No LOCKED state or counter is built, and `lock` is unconnected internally.
  - Every grant lasts exactly one cycle.

## Structure
- Package `dff_arb_pkg` holds:
  - the state enum `arb_state_e` (IDLE, GRANT, LOCKED);
  - the localparam for the owner-index width;
  - the default N_REQ/WIDTH/MAX_LOCK constants shared with the bench.
- Sub-module `rr_pick`: combinational round-robin picker. Inputs are `req` and `ptr`; outputs are `valid`, the winner index and the one-hot winner. It is instantiated once and unit-testable alone.

## Test plan
- Reset: hold `rst` 10 cycles with `req`=4'b1111 -> `gnt`=0, `dff_en`=0, `dff_d`=0 throughout. After release, the first grant goes to requester 0.
- Single request: `req`=4'b0100, data[2]=8'hA5 -> `gnt`=4'b0100 and `dff_d`=8'hA5 one cycle later. `dff` q=8'hA5 the cycle after that.
- Rotation and wrap: `req`=4'b1111 held, data[i]=8'h10+i -> grants 0,1,2,3,0 on alternating cycles, `dff_d` 8'h10,8'h11,8'h12,8'h13,8'h10.
- Withdrawal: `req`=4'b0011 with `ptr`=0; requester 1 drops `req` during the grant to 0 -> the next grant goes to 0, and 1 is never granted.
- Reset mid-grant: assert `rst` in the cycle `gnt`=4'b0010 -> the next cycle shows `gnt`=0, `dff_en`=0, `owner`=0.
- Lock (`DFF_ARB_LOCK_EN`, MAX_LOCK=8): `req[1]` and `lock[1]` held high -> `gnt`=4'b0010 for exactly 8 consecutive cycles, then IDLE for one cycle. With the macro undefined, the same stimulus gives 1-cycle grants.
